// File: rtl/toggle_period_monitor.sv
// Synchronizes a free-running toggle, measures each half-period in clock
// cycles and raises sticky flags for intervals outside [MIN_HALF, MAX_HALF].
module toggle_period_monitor #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int MIN_HALF    = 40,
  parameter int MAX_HALF    = 60
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             clear_stats,
  input  logic             toggle_in,
  output logic             level,
  output logic [CNT_W-1:0] half_period,
  output logic             period_valid,
  output logic [15:0]      edge_count,
  output logic             too_short,
  output logic             timeout
);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    MEASURE
  } state_t;

  localparam logic [CNT_W-1:0] MIN_L = CNT_W'(MIN_HALF);
  localparam logic [CNT_W-1:0] MAX_L = CNT_W'(MAX_HALF);

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   level_prev;
  logic                   edge_det;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_inc;
  logic                   count_evt;
  logic                   short_evt;
  logic                   timeout_evt;

  // Synchronizer and edge history run regardless of enable
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q     <= '0;
      level_prev <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], toggle_in};
      level_prev <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level    = sync_q[SYNC_STAGES-1];
  assign edge_det = level ^ level_prev;

  // The counter holds at all-ones instead of wrapping back to a short value
  assign cnt_inc     = (cnt == '1) ? cnt : cnt + CNT_W'(1);
  assign count_evt   = enable && edge_det;
  assign short_evt   = enable && (state == MEASURE) && edge_det && (cnt_inc < MIN_L);
  assign timeout_evt = enable && (state == MEASURE) && !edge_det && (cnt_inc >= MAX_L);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      cnt          <= '0;
      half_period  <= '0;
      period_valid <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      if (!enable) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            state <= ARMED;
            cnt   <= '0;
          end
          ARMED: begin
            cnt <= '0;
            if (edge_det) begin
              state <= MEASURE;
            end
          end
          MEASURE: begin
            if (edge_det) begin
              half_period  <= cnt_inc;
              period_valid <= 1'b1;
              cnt          <= '0;
            end else if (cnt_inc >= MAX_L) begin
              // A missing edge discards the interval; the next edge only re-arms
              state <= ARMED;
              cnt   <= '0;
            end else begin
              cnt <= cnt_inc;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

  // Events in the same cycle as clear_stats take priority over the clear
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      edge_count <= '0;
      too_short  <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      if (count_evt) begin
        edge_count <= clear_stats ? 16'd1 : edge_count + 16'd1;
      end else if (clear_stats) begin
        edge_count <= '0;
      end

      if (short_evt) begin
        too_short <= 1'b1;
      end else if (clear_stats) begin
        too_short <= 1'b0;
      end

      if (timeout_evt) begin
        timeout <= 1'b1;
      end else if (clear_stats) begin
        timeout <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_toggle_period_monitor.sv
// Directed bench for toggle_period_monitor: edges reach the counters three
// clocks after toggle_in changes, so intervals are set by the gaps between flips.
module tb_toggle_period_monitor;

  logic        clock;
  logic        reset_n;
  logic        enable;
  logic        clear_stats;
  logic        toggle_in;
  logic        level;
  logic [15:0] half_period;
  logic        period_valid;
  logic [15:0] edge_count;
  logic        too_short;
  logic        timeout;

  int compared   = 0;
  int mismatched = 0;
  int pvCount    = 0;
  int pvBase     = 0;

  toggle_period_monitor #(
    .CNT_W      (16),
    .SYNC_STAGES(2),
    .MIN_HALF   (40),
    .MAX_HALF   (60)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .enable      (enable),
    .clear_stats (clear_stats),
    .toggle_in   (toggle_in),
    .level       (level),
    .half_period (half_period),
    .period_valid(period_valid),
    .edge_count  (edge_count),
    .too_short   (too_short),
    .timeout     (timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Count period_valid pulses on the falling edge, away from the active edge
  always @(negedge clock) begin
    if (period_valid === 1'b1) pvCount++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic flip();
    toggle_in = ~toggle_in;
  endtask

  task automatic pulseClear();
    clear_stats = 1'b1;
    tick(1);
    clear_stats = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n     = 1'b0;
    enable      = 1'b0;
    clear_stats = 1'b0;
    toggle_in   = 1'b0;
    tick(3);
    checkOutput("rst_level", level, 0);
    checkOutput("rst_half", half_period, 0);
    checkOutput("rst_pv", period_valid, 0);
    checkOutput("rst_ecount", edge_count, 0);
    checkOutput("rst_short", too_short, 0);
    checkOutput("rst_timeout", timeout, 0);

    // Nominal 50-cycle toggle, six edges
    reset_n = 1'b1;
    enable  = 1'b1;
    tick(3);
    flip();
    tick(2);
    checkOutput("lat_level", level, 1);
    checkOutput("lat_ecount_early", edge_count, 0);
    tick(1);
    checkOutput("lat_ecount", edge_count, 1);
    tick(47);
    flip();
    for (int i = 0; i < 4; i++) begin
      tick(50);
      flip();
    end
    tick(4);
    checkOutput("nom_pv_count", pvCount, 5);
    checkOutput("nom_half", half_period, 50);
    checkOutput("nom_ecount", edge_count, 6);
    checkOutput("nom_short", too_short, 0);
    checkOutput("nom_timeout", timeout, 0);

    // Short 30-cycle interval sets a sticky too_short
    tick(26);
    flip();
    tick(4);
    checkOutput("short_half", half_period, 30);
    checkOutput("short_flag", too_short, 1);
    checkOutput("short_pv_count", pvCount, 6);
    tick(46);
    flip();
    tick(4);
    checkOutput("sticky_half", half_period, 50);
    checkOutput("sticky_short", too_short, 1);
    pulseClear();
    checkOutput("clr_short", too_short, 0);
    checkOutput("clr_ecount", edge_count, 0);
    checkOutput("clr_half_kept", half_period, 50);

    // Static toggle: timeout exactly 60 cycles after the last edge
    tick(57);
    checkOutput("to_before", timeout, 0);
    tick(1);
    checkOutput("to_at_60", timeout, 1);
    pvBase = pvCount;
    tick(10);
    flip();
    tick(4);
    checkOutput("rearm_no_pv", pvCount, pvBase);
    checkOutput("rearm_ecount", edge_count, 1);
    tick(36);
    flip();
    tick(4);
    checkOutput("min_pv", pvCount, pvBase + 1);
    checkOutput("min_half", half_period, 40);
    checkOutput("min_not_short", too_short, 0);
    checkOutput("to_sticky", timeout, 1);
    pulseClear();
    checkOutput("clr_timeout", timeout, 0);
    checkOutput("clr_ecount2", edge_count, 0);
    tick(55);
    flip();
    tick(4);
    checkOutput("max_half", half_period, 60);
    checkOutput("max_no_timeout", timeout, 0);
    checkOutput("max_pv", pvCount, pvBase + 2);

    // clear_stats coinciding with a detected edge
    tick(46);
    flip();
    tick(2);
    clear_stats = 1'b1;
    tick(1);
    clear_stats = 1'b0;
    checkOutput("clr_edge_ecount", edge_count, 1);

    // Enable dropped for 10 cycles mid-interval
    tick(20);
    enable = 1'b0;
    tick(10);
    enable = 1'b1;
    pvBase = pvCount;
    tick(17);
    flip();
    tick(4);
    checkOutput("en_no_pv", pvCount, pvBase);
    checkOutput("en_arm_ecount", edge_count, 2);
    tick(51);
    flip();
    tick(4);
    checkOutput("en_pv", pvCount, pvBase + 1);
    checkOutput("en_half", half_period, 55);
    checkOutput("en_ecount", edge_count, 3);

    // Asynchronous reset between clock edges, mid-measurement
    tick(10);
    #3;
    reset_n   = 1'b0;
    toggle_in = 1'b0;
    #1;
    checkOutput("arst_level", level, 0);
    checkOutput("arst_half", half_period, 0);
    checkOutput("arst_pv", period_valid, 0);
    checkOutput("arst_ecount", edge_count, 0);
    checkOutput("arst_short", too_short, 0);
    checkOutput("arst_timeout", timeout, 0);
    #2;
    reset_n = 1'b1;
    tick(4);
    checkOutput("post_level", level, 0);
    checkOutput("post_ecount", edge_count, 0);
    pvBase = pvCount;
    flip();
    tick(50);
    flip();
    tick(4);
    checkOutput("post_half", half_period, 50);
    checkOutput("post_ecount2", edge_count, 2);
    checkOutput("post_pv", pvCount, pvBase + 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/toggle_period_monitor.md
Name: toggle_period_monitor

Overview:
- Consumes a free-running square-wave toggle produced by the timescale demo stimulus modules.
- Synchronizes the toggle into the clock domain and detects its edges.
- Measures each half-period in clock cycles and flags out-of-window intervals.
- Sits directly downstream of the toggle generator as the bench-side checker for timescale and delay behaviour.

Parameters:
- CNT_W, 16, width of the interval counter and the half_period output.
- SYNC_STAGES, 2, number of flip-flops in the input synchronizer; legal values are 2..4.
- MIN_HALF, 40, smallest legal half-period in clock cycles.
- MAX_HALF, 60, largest legal half-period in clock cycles; must satisfy MAX_HALF < 2^CNT_W - 1.

Ports:
- clock  input  1  sole clock; all state updates on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- enable  input  1  measurement enable.
- clear_stats  input  1  synchronous clear of edge_count and the sticky flags.
- toggle_in  input  1  asynchronous toggle from the upstream generator.
- level  output  1  synchronized toggle level.
- half_period  output  CNT_W  last measured half-period, in cycles.
- period_valid  output  1  one-cycle pulse when half_period updates.
- edge_count  output  16  detected edges; wraps modulo 2^16.
- too_short  output  1  sticky; set when a measured interval is < MIN_HALF.
- timeout  output  1  sticky; set when no edge arrives within MAX_HALF cycles.

Behaviour:
- Reset (asynchronous, while reset_n = 0):
  - All synchronizer flops, level, half_period, period_valid, edge_count, too_short and timeout are 0.
  - Interval counter is 0; state is IDLE.
- Synchronizer: always runs, regardless of enable. level is the last synchronizer stage. An edge is level XOR its previous registered value. Latency from a toggle_in change to the edge pulse is SYNC_STAGES+1 cycles.
- State machine:
  - IDLE: entered from reset, or whenever enable = 0. Counter is held at 0. Goes to ARMED when enable = 1.
  - ARMED: waits for an edge. On an edge: counter is set to 0 and the state goes to MEASURE. No measurement is reported for this edge.
  - MEASURE: counter increments every cycle, saturating at all-ones.
    - On an edge: half_period <= counter + 1 (the number of cycles between the two edges). period_valid pulses in the same cycle. Counter is set to 0.
    - If counter + 1 < MIN_HALF on that edge, too_short is set.
    - If counter reaches MAX_HALF with no edge, timeout is set and the state returns to ARMED. The next edge restarts measurement and is not reported.
  - enable = 0 in any state forces IDLE on the next clock. half_period and the flags retain their values; period_valid is 0.
- edge_count increments on every detected edge while enable = 1, including the arming edge.
- clear_stats:
  - Clears edge_count, too_short and timeout.
  - If an edge or flag event occurs in the same cycle, the event wins: edge_count becomes 1 and the flag is set.
  - half_period is not affected.
- Counter arithmetic is unsigned, CNT_W bits. half_period never wraps.
- Reset asserted mid-measurement clears everything immediately; there is no partial measurement.

Test Plan:
- Reset, enable = 1, toggle_in flips every 50 cycles for 6 edges -> first edge after 3 cycles of latency; 5 period_valid pulses with half_period = 50; edge_count = 6; too_short = 0; timeout = 0.
- Toggle every 30 cycles -> half_period = 30 and too_short = 1 after the second edge; the flag stays 1 after the toggle returns to 50 cycles; clear_stats clears it.
- Hold toggle_in static after 2 edges -> timeout = 1 exactly 60 cycles after the last edge. The next edge produces no period_valid; the edge after that reports the true interval.
- clear_stats asserted in the same cycle as a detected edge -> edge_count = 1.
- Drop enable mid-interval for 10 cycles, then restore it -> no period_valid for the broken interval; the first edge re-arms; the second edge reports a correct half_period.
- Assert reset_n = 0 asynchronously, between clock edges, mid-MEASURE -> all outputs read 0 before the next clock edge; after release, behaviour matches a fresh start.
